// File: rtl/hazard_pkg.sv
// hazard_pkg: shared FSM encodings and register-index constants for the hazard unit
package hazard_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, DWAIT = 2'd1, DRESYNC = 2'd2} hz_state_e;
  localparam int DEF_REG_IDX_W = 5;
  localparam logic [DEF_REG_IDX_W-1:0] X0 = '0;
endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// hazard_ctrl_unit_if: pipeline-to-hazard-unit signal bundle; master is the core, slave the hazard unit
interface hazard_ctrl_unit_if #(
  parameter int REG_IDX_W = hazard_pkg::DEF_REG_IDX_W,
  parameter int CNT_W = 3
);
  logic id_valid_i;
  logic [REG_IDX_W-1:0] id_rs1_i;
  logic [REG_IDX_W-1:0] id_rs2_i;
  logic id_rs1_used_i;
  logic id_rs2_used_i;
  logic [REG_IDX_W-1:0] id_rd_i;
  logic id_rd_wen_i;
  logic id_is_long_i;
  logic ex_valid_i;
  logic ex_is_load_i;
  logic [REG_IDX_W-1:0] ex_rd_i;
  logic long_done_i;
  logic [REG_IDX_W-1:0] long_done_rd_i;
  logic redirect_i;
  logic icache_ready_i;
  logic dcache_ready_i;
  logic if_stall_o;
  logic id_stall_o;
  logic id_bubble_o;
  logic flush_o;
  logic mem_busy_o;
  logic [CNT_W-1:0] pending_cnt_o;
  logic [1:0] state_o;
  modport master (
    output id_valid_i, id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i, id_rd_i, id_rd_wen_i,
           id_is_long_i, ex_valid_i, ex_is_load_i, ex_rd_i, long_done_i, long_done_rd_i,
           redirect_i, icache_ready_i, dcache_ready_i,
    input  if_stall_o, id_stall_o, id_bubble_o, flush_o, mem_busy_o, pending_cnt_o, state_o
  );
  modport slave (
    input  id_valid_i, id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i, id_rd_i, id_rd_wen_i,
           id_is_long_i, ex_valid_i, ex_is_load_i, ex_rd_i, long_done_i, long_done_rd_i,
           redirect_i, icache_ready_i, dcache_ready_i,
    output if_stall_o, id_stall_o, id_bubble_o, flush_o, mem_busy_o, pending_cnt_o, state_o
  );
endinterface

// File: rtl/hazard_ctrl_unit_scoreboard.sv
// reg_scoreboard: per-register pending bits with counter and same-cycle completion bypass
module reg_scoreboard
  import hazard_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int REG_IDX_W = DEF_REG_IDX_W,
  parameter int MAX_PENDING = 4,
  parameter int CNT_W = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic set_i,
  input  logic [REG_IDX_W-1:0] set_idx_i,
  input  logic clr_i,
  input  logic [REG_IDX_W-1:0] clr_idx_i,
  output logic [NUM_REGS-1:0] pend_eff_o,
  output logic full_o,
  output logic [CNT_W-1:0] cnt_o
);
  logic [NUM_REGS-1:0] pend, set_v, clr_v;
  logic [CNT_W-1:0] cnt_eff;
  logic set_ok, clr_ok;
  assign clr_v = clr_i && clr_idx_i != REG_IDX_W'(X0) ? NUM_REGS'(1) << clr_idx_i : '0;
  assign set_v = set_i && set_idx_i != REG_IDX_W'(X0) ? NUM_REGS'(1) << set_idx_i : '0;
  assign clr_ok = |(pend & clr_v);
  assign pend_eff_o = pend & ~clr_v;
  assign cnt_eff = cnt_o - CNT_W'(clr_ok);
  assign full_o = cnt_eff == CNT_W'(MAX_PENDING);
  // a set only counts when it creates a new pending bit and there is room
  assign set_ok = |(set_v & ~pend_eff_o) && !full_o;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      pend <= '0;
      cnt_o <= '0;
    end else begin
      pend <= pend_eff_o | (set_ok ? set_v : '0);
      cnt_o <= cnt_eff + CNT_W'(set_ok);
    end
endmodule

// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: stall/bubble/flush control with long-op scoreboard and data-cache resync FSM
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int REG_IDX_W = DEF_REG_IDX_W,
  parameter int MAX_PENDING = 4,
  parameter int CNT_W = 3
) (
  input logic clk_i,
  input logic rst_i,
  hazard_ctrl_unit_if.slave hz
);
  hz_state_e state;
  logic redirect_pend, mem_busy, load_use, raw, waw, full, haz, id_stall, flush, issue, sb_full;
  logic [NUM_REGS-1:0] pend_eff;
  logic [CNT_W-1:0] cnt;
  reg_scoreboard #(
    .NUM_REGS(NUM_REGS), .REG_IDX_W(REG_IDX_W), .MAX_PENDING(MAX_PENDING), .CNT_W(CNT_W)
  ) u_sb (
    .clk_i(clk_i), .rst_i(rst_i),
    .set_i(issue), .set_idx_i(hz.id_rd_i),
    .clr_i(hz.long_done_i), .clr_idx_i(hz.long_done_rd_i),
    .pend_eff_o(pend_eff), .full_o(sb_full), .cnt_o(cnt)
  );
  assign mem_busy = state != RUN || !hz.dcache_ready_i || !hz.icache_ready_i;
  assign load_use = hz.ex_valid_i && hz.ex_is_load_i && hz.ex_rd_i != REG_IDX_W'(X0) &&
                    ((hz.id_rs1_used_i && hz.id_rs1_i == hz.ex_rd_i) ||
                     (hz.id_rs2_used_i && hz.id_rs2_i == hz.ex_rd_i));
  assign raw = (hz.id_rs1_used_i && pend_eff[hz.id_rs1_i]) || (hz.id_rs2_used_i && pend_eff[hz.id_rs2_i]);
  assign waw = hz.id_rd_wen_i && pend_eff[hz.id_rd_i];
  assign full = hz.id_is_long_i && sb_full;
  assign haz = hz.id_valid_i && (load_use || raw || waw || full);
  assign id_stall = haz || mem_busy;
  assign flush = hz.redirect_i || redirect_pend;
  assign issue = hz.id_valid_i && !id_stall && !flush && hz.id_is_long_i && hz.id_rd_wen_i &&
                 hz.id_rd_i != REG_IDX_W'(X0);
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state <= RUN;
      redirect_pend <= 1'b0;
    end else begin
      state <= state == RUN   ? (hz.dcache_ready_i ? RUN : DWAIT) :
               state == DWAIT ? (hz.dcache_ready_i ? DRESYNC : DWAIT) :
                                (hz.dcache_ready_i ? RUN : DWAIT);
      redirect_pend <= mem_busy && (hz.redirect_i || redirect_pend);
    end
  // combinational outputs are forced low while reset is held
  assign hz.id_stall_o = id_stall && !rst_i;
  assign hz.if_stall_o = id_stall && !rst_i;
  assign hz.id_bubble_o = haz && !mem_busy && !flush && !rst_i;
  assign hz.flush_o = flush && !rst_i;
  assign hz.mem_busy_o = mem_busy && !rst_i;
  assign hz.pending_cnt_o = cnt;
  assign hz.state_o = state;
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb_hazard_ctrl_unit: directed self-checking bench for hazard_ctrl_unit
module tb_hazard_ctrl_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_err = 0;
  hazard_ctrl_unit_if hz ();
  hazard_ctrl_unit dut (.clk_i(clk), .rst_i(rst), .hz(hz));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic chk_o(input string tag, input logic s, input logic b, input logic f, input logic m);
    chk({tag, ".id_stall"}, 32'(hz.id_stall_o), 32'(s));
    chk({tag, ".if_stall"}, 32'(hz.if_stall_o), 32'(s));
    chk({tag, ".bubble"}, 32'(hz.id_bubble_o), 32'(b));
    chk({tag, ".flush"}, 32'(hz.flush_o), 32'(f));
    chk({tag, ".mem_busy"}, 32'(hz.mem_busy_o), 32'(m));
  endtask
  task automatic idle();
    hz.id_valid_i = 0; hz.id_rs1_i = 0; hz.id_rs2_i = 0; hz.id_rs1_used_i = 0; hz.id_rs2_used_i = 0;
    hz.id_rd_i = 0; hz.id_rd_wen_i = 0; hz.id_is_long_i = 0; hz.ex_valid_i = 0; hz.ex_is_load_i = 0;
    hz.ex_rd_i = 0; hz.long_done_i = 0; hz.long_done_rd_i = 0; hz.redirect_i = 0;
    hz.icache_ready_i = 1; hz.dcache_ready_i = 1;
  endtask
  task automatic id_long(input logic [4:0] rd);
    hz.id_valid_i = 1; hz.id_is_long_i = 1; hz.id_rd_wen_i = 1; hz.id_rd_i = rd;
  endtask
  task automatic done(input logic [4:0] rd);
    hz.long_done_i = 1; hz.long_done_rd_i = rd;
  endtask
  task automatic load_use5();
    hz.ex_valid_i = 1; hz.ex_is_load_i = 1; hz.ex_rd_i = 5;
    hz.id_valid_i = 1; hz.id_rs1_i = 5; hz.id_rs1_used_i = 1;
  endtask
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask
  task automatic smp();
    @(negedge clk);
  endtask
  initial begin
    int drain_rd[4] = '{1, 3, 4, 9};
    idle(); hz.dcache_ready_i = 0; hz.redirect_i = 1;
    smp(); chk_o("rst", 0, 0, 0, 0); chk("rst.cnt", 32'(hz.pending_cnt_o), 0); chk("rst.state", 32'(hz.state_o), 0);
    nxt(); rst = 0; idle();
    smp(); chk_o("idle", 0, 0, 0, 0);
    nxt(); load_use5();
    smp(); chk_o("lu", 1, 1, 0, 0);
    nxt(); hz.ex_valid_i = 0;
    smp(); chk_o("lu_rel", 0, 0, 0, 0);
    nxt(); hz.ex_valid_i = 1; hz.ex_rd_i = 0; hz.id_rs1_i = 0;
    smp(); chk_o("lu_x0", 0, 0, 0, 0);
    nxt(); hz.ex_rd_i = 5; hz.id_rs1_i = 3; hz.id_rs2_i = 5;
    smp(); chk_o("lu_unused", 0, 0, 0, 0);
    nxt(); idle(); id_long(7);
    smp(); chk_o("mul_iss", 0, 0, 0, 0);
    nxt(); idle(); hz.id_valid_i = 1; hz.id_rs2_i = 7; hz.id_rs2_used_i = 1;
    smp(); chk_o("raw", 1, 1, 0, 0); chk("raw.cnt", 32'(hz.pending_cnt_o), 1);
    nxt(); smp(); chk_o("raw_hold", 1, 1, 0, 0);
    nxt(); idle(); id_long(7);
    smp(); chk_o("waw", 1, 1, 0, 0);
    nxt(); idle(); hz.id_valid_i = 1; hz.id_rs2_i = 7; hz.id_rs2_used_i = 1; done(7);
    smp(); chk_o("raw_byp", 0, 0, 0, 0); chk("raw_byp.cnt", 32'(hz.pending_cnt_o), 1);
    nxt(); idle();
    smp(); chk("mul_done.cnt", 32'(hz.pending_cnt_o), 0);
    for (int r = 1; r <= 4; r++) begin
      nxt(); idle(); id_long(5'(r));
      smp(); chk_o("fill", 0, 0, 0, 0);
    end
    nxt(); idle(); id_long(9);
    smp(); chk_o("full", 1, 1, 0, 0); chk("full.cnt", 32'(hz.pending_cnt_o), 4);
    nxt(); done(2);
    smp(); chk_o("full_byp", 0, 0, 0, 0); chk("full_byp.cnt", 32'(hz.pending_cnt_o), 4);
    nxt(); idle(); done(2);
    smp(); chk("swap.cnt", 32'(hz.pending_cnt_o), 4);
    nxt(); idle(); done(0);
    smp(); chk("ign_np.cnt", 32'(hz.pending_cnt_o), 4);
    nxt(); idle(); hz.id_valid_i = 1; hz.id_rs1_i = 9; hz.id_rs1_used_i = 1;
    smp(); chk("ign_x0.cnt", 32'(hz.pending_cnt_o), 4); chk_o("raw9", 1, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      nxt(); idle(); done(5'(drain_rd[i]));
      smp(); chk("drain.cnt", 32'(hz.pending_cnt_o), 32'(4 - i));
    end
    nxt(); idle();
    smp(); chk("drained.cnt", 32'(hz.pending_cnt_o), 0);
    nxt(); idle(); id_long(6);
    smp(); chk_o("iss6", 0, 0, 0, 0);
    nxt(); idle(); id_long(6); done(6);
    smp(); chk_o("same_rd", 0, 0, 0, 0); chk("same_rd.cnt", 32'(hz.pending_cnt_o), 1);
    nxt(); idle(); hz.id_valid_i = 1; hz.id_rs1_i = 6; hz.id_rs1_used_i = 1;
    smp(); chk_o("set_wins", 1, 1, 0, 0); chk("set_wins.cnt", 32'(hz.pending_cnt_o), 1);
    nxt(); idle(); done(6);
    nxt(); idle();
    smp(); chk("sw_clr.cnt", 32'(hz.pending_cnt_o), 0);
    nxt(); idle(); hz.dcache_ready_i = 0;
    smp(); chk_o("dw0", 1, 0, 0, 1); chk("dw0.state", 32'(hz.state_o), 0);
    nxt(); smp(); chk_o("dw1", 1, 0, 0, 1); chk("dw1.state", 32'(hz.state_o), 1);
    nxt(); load_use5();
    smp(); chk_o("dw2_haz", 1, 0, 0, 1); chk("dw2.state", 32'(hz.state_o), 1);
    nxt(); idle();
    smp(); chk_o("dw3", 1, 0, 0, 1); chk("dw3.state", 32'(hz.state_o), 1);
    nxt(); smp(); chk_o("resync", 1, 0, 0, 1); chk("resync.state", 32'(hz.state_o), 2);
    nxt(); smp(); chk_o("run", 0, 0, 0, 0); chk("run.state", 32'(hz.state_o), 0);
    nxt(); idle(); hz.dcache_ready_i = 0; hz.redirect_i = 1;
    smp(); chk_o("rdb0", 1, 0, 1, 1);
    nxt(); hz.redirect_i = 0;
    smp(); chk_o("rdb1", 1, 0, 1, 1);
    nxt(); hz.dcache_ready_i = 1;
    smp(); chk_o("rdb2", 1, 0, 1, 1);
    nxt(); smp(); chk_o("rdb3", 1, 0, 1, 1);
    nxt(); smp(); chk_o("rdb_last", 0, 0, 1, 0);
    nxt(); smp(); chk_o("rdb_clr", 0, 0, 0, 0);
    nxt(); idle(); hz.redirect_i = 1; id_long(8);
    smp(); chk_o("rd_iss", 0, 0, 1, 0);
    nxt(); idle();
    smp(); chk_o("rd_once", 0, 0, 0, 0); chk("rd_noiss.cnt", 32'(hz.pending_cnt_o), 0);
    nxt(); hz.redirect_i = 1; load_use5();
    smp(); chk_o("rd_lu", 1, 0, 1, 0);
    for (int r = 10; r <= 12; r++) begin
      nxt(); idle(); id_long(5'(r));
      smp();
    end
    nxt(); idle(); hz.dcache_ready_i = 0;
    smp(); chk("pre_rst.cnt", 32'(hz.pending_cnt_o), 3); chk("pre_rst.state", 32'(hz.state_o), 0);
    nxt(); smp(); chk("pre_rst.dwait", 32'(hz.state_o), 1); chk_o("pre_rst", 1, 0, 0, 1);
    #2 rst = 1;
    #1 chk_o("arst", 0, 0, 0, 0); chk("arst.cnt", 32'(hz.pending_cnt_o), 0); chk("arst.state", 32'(hz.state_o), 0);
    nxt(); rst = 0; idle();
    smp(); chk_o("post_rst", 0, 0, 0, 0); chk("post_rst.cnt", 32'(hz.pending_cnt_o), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
